ptw_mem_arbiter: RTL and testbench

- Shares the single page-table-walk memory port between NUM_REQ MMU walkers (default: instruction-side and data-side MMU).
- Each walk may issue several PTE reads (one per level). A walk holds the port until its final read, so walks never interleave.
- Round-robin arbitration between walks; per-access timeout releases a hung port.
- Sits between the MMU walkers and the memory/cache interface.

---
 rtl/walk_arb_pkg.sv | 23 ++
 rtl/rr_picker.sv | 32 +++
 rtl/ptw_mem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_ptw_mem_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/walk_arb_pkg.sv
// Shared types and helpers for the page-table-walk memory arbiter.
package walk_arb_pkg;

  // Arbiter states: port free, read outstanding, owner between walk levels.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

  localparam int unsigned TIMEOUT_CNT_W = 16;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first requester at or after ptr wins.
module rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [IDX_W-1:0]   idx_c,
  output logic               any_c
);

  logic found;

  // Walk offsets 0..NUM_REQ-1 from ptr; the first set request is granted.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!found && req[i] && (((int'(ptr) + k) % int'(NUM_REQ)) == i)) begin
          found    = 1'b1;
          gnt_c[i] = 1'b1;
          idx_c    = IDX_W'(i);
        end
      end
    end
    any_c = found;
  end

endmodule

// File: rtl/ptw_mem_arbiter.sv
// Shares one PTE read port between MMU walkers; a walk owns the port until its
// final read, with round-robin between walks and a per-access timeout.
module ptw_mem_arbiter
  import walk_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 48,
  parameter int unsigned DATA_W  = 48,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ-1:0]        rsp_err,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_read,
  input  logic [DATA_W-1:0]         mem_data,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic [TIMEOUT_CNT_W-1:0]  timeout_count
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
  localparam int unsigned TMR_W = clog2(TIMEOUT);

  arb_state_t               state_q, state_d;
  logic [NUM_REQ-1:0]       gnt_q, gnt_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic                     mem_read_q, mem_read_d;
  logic                     last_q, last_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic [TIMEOUT_CNT_W-1:0] tcnt_q, tcnt_d;

  logic [NUM_REQ-1:0] pick_gnt_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic               pick_any_c;

  logic [NUM_REQ-1:0] sel_oh_c;
  logic [ADDR_W-1:0]  sel_addr_c;
  logic               sel_last_c;
  logic               owner_req_c;
  logic               timer_exp_c;
  logic               done_c;
  logic               tmo_c;
  logic [IDX_W-1:0]   next_ptr_c;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .gnt_c (pick_gnt_c),
    .idx_c (pick_idx_c),
    .any_c (pick_any_c)
  );

  // Completion / timeout events and the pointer value used on release.
  always_comb begin
    owner_req_c = |(gnt_q & req_valid);
    timer_exp_c = (timer_q == TMR_W'(TIMEOUT - 1));
    done_c      = (state_q == BUSY) && mem_ready;
    tmo_c       = ((state_q == BUSY) && !mem_ready && timer_exp_c) ||
                  ((state_q == HOLD) && !owner_req_c && timer_exp_c);
    next_ptr_c  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
  end

  // Request fields of the new winner in IDLE, or of the owner otherwise.
  always_comb begin
    sel_oh_c   = (state_q == IDLE) ? pick_gnt_c : gnt_q;
    sel_addr_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (sel_oh_c[i]) sel_addr_c = req_addr[i*ADDR_W +: ADDR_W];
    end
    sel_last_c = |(sel_oh_c & req_last);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pick_any_c) state_d = BUSY;
      BUSY: begin
        if (done_c)     state_d = last_q ? IDLE : HOLD;
        else if (tmo_c) state_d = IDLE;
      end
      HOLD: begin
        if (owner_req_c) state_d = BUSY;
        else if (tmo_c)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response outputs are combinational so the owner sees data with mem_ready.
  always_comb begin
    rsp_valid = '0;
    rsp_err   = '0;
    rsp_data  = '0;
    if (done_c) begin
      rsp_valid = gnt_q;
      rsp_data  = mem_data;
    end
    if (tmo_c) rsp_err = gnt_q;
  end

  // Next values for ownership, address, timer and counters.
  always_comb begin
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    mem_addr_d = mem_addr_q;
    mem_read_d = mem_read_q;
    last_d     = last_q;
    timer_d    = timer_q;
    tcnt_d     = tcnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any_c) begin
          owner_d    = pick_idx_c;
          gnt_d      = pick_gnt_c;
          mem_addr_d = sel_addr_c;
          last_d     = sel_last_c;
          timer_d    = '0;
          mem_read_d = 1'b1;
        end
      end
      BUSY: begin
        if (done_c) begin
          mem_read_d = 1'b0;
          timer_d    = '0;
          if (last_q) begin
            gnt_d    = '0;
            rr_ptr_d = next_ptr_c;
          end
        end else if (tmo_c) begin
          mem_read_d = 1'b0;
          gnt_d      = '0;
          rr_ptr_d   = next_ptr_c;
          timer_d    = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      HOLD: begin
        if (owner_req_c) begin
          mem_addr_d = sel_addr_c;
          last_d     = sel_last_c;
          timer_d    = '0;
          mem_read_d = 1'b1;
        end else if (tmo_c) begin
          gnt_d    = '0;
          rr_ptr_d = next_ptr_c;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: ;
    endcase
    if (tmo_c && (tcnt_q != {TIMEOUT_CNT_W{1'b1}})) tcnt_d = tcnt_q + TIMEOUT_CNT_W'(1);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      mem_addr_q <= '0;
      mem_read_q <= 1'b0;
      last_q     <= 1'b0;
      timer_q    <= '0;
      tcnt_q     <= '0;
    end else begin
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      mem_addr_q <= mem_addr_d;
      mem_read_q <= mem_read_d;
      last_q     <= last_d;
      timer_q    <= timer_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign gnt           = gnt_q;
  assign mem_addr      = mem_addr_q;
  assign mem_read      = mem_read_q;
  assign busy          = (state_q != IDLE);
  assign timeout_count = tcnt_q;

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Directed bench: dut_a uses the default timeout, dut_b a timeout of 8 cycles.
module tb_ptw_mem_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 48;
  localparam int unsigned DW = 48;

  logic              clk;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     req_last;
  logic [DW-1:0]     mem_data;
  logic              mem_ready;

  logic [NR-1:0] gnt_a, rsp_valid_a, rsp_err_a;
  logic [DW-1:0] rsp_data_a;
  logic [AW-1:0] mem_addr_a;
  logic          mem_read_a, busy_a;
  logic [15:0]   tcnt_a;

  logic [NR-1:0] gnt_b, rsp_valid_b, rsp_err_b;
  logic [DW-1:0] rsp_data_b;
  logic [AW-1:0] mem_addr_b;
  logic          mem_read_b, busy_b;
  logic [15:0]   tcnt_b;

  int checks = 0;
  int errors = 0;

  ptw_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(256)) dut_a (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_last(req_last), .gnt(gnt_a), .rsp_valid(rsp_valid_a), .rsp_err(rsp_err_a),
    .rsp_data(rsp_data_a), .mem_addr(mem_addr_a), .mem_read(mem_read_a),
    .mem_data(mem_data), .mem_ready(mem_ready), .busy(busy_a), .timeout_count(tcnt_a)
  );

  ptw_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_last(req_last), .gnt(gnt_b), .rsp_valid(rsp_valid_b), .rsp_err(rsp_err_b),
    .rsp_data(rsp_data_b), .mem_addr(mem_addr_b), .mem_read(mem_read_b),
    .mem_data(mem_data), .mem_ready(mem_ready), .busy(busy_b), .timeout_count(tcnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One PTE read on dut_a, memory answering in the second BUSY cycle.
  // Called in a cycle where the arbiter (IDLE or HOLD) will sample the request.
  task automatic access(input int r, input logic [AW-1:0] addr, input logic last,
                        input logic [DW-1:0] data, input string tag);
    logic [NR-1:0] oh;
    oh = NR'(1) << r;
    req_valid[r] = 1'b1;
    req_addr[r*AW +: AW] = addr;
    req_last[r] = last;
    cyc();
    #1;
    chk({tag, "_gnt"},      64'(gnt_a),       64'(oh));
    chk({tag, "_mem_read"}, 64'(mem_read_a),  64'd1);
    chk({tag, "_mem_addr"}, 64'(mem_addr_a),  64'(addr));
    chk({tag, "_no_rsp"},   64'(rsp_valid_a), 64'd0);
    cyc();
    mem_ready = 1'b1;
    mem_data  = data;
    #1;
    chk({tag, "_rsp_valid"}, 64'(rsp_valid_a), 64'(oh));
    chk({tag, "_rsp_data"},  64'(rsp_data_a),  64'(data));
    chk({tag, "_rsp_err"},   64'(rsp_err_a),   64'd0);
    cyc();
    mem_ready    = 1'b0;
    mem_data     = '0;
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
    #1;
    chk({tag, "_read_drop"}, 64'(mem_read_a), 64'd0);
    chk({tag, "_gnt_after"}, 64'(gnt_a), last ? 64'd0 : 64'(oh));
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_last  = '0;
    mem_data  = '0;
    mem_ready = 1'b0;
    repeat (2) cyc();
    #1;
    chk("reset_gnt",      64'(gnt_a),      64'd0);
    chk("reset_mem_read", 64'(mem_read_a), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr_a), 64'd0);
    chk("reset_busy",     64'(busy_a),     64'd0);
    chk("reset_tcnt",     64'(tcnt_a),     64'd0);
    reset_n = 1'b1;

    // Single three-level walk from requester 0.
    access(0, 48'h1000, 1'b0, 48'hA1A1_0000_0001, "walk_l1");
    access(0, 48'h2008, 1'b0, 48'hA2A2_0000_0002, "walk_l2");
    access(0, 48'h3010, 1'b1, 48'hA3A3_0000_0003, "walk_l3");
    chk("walk_end_busy", 64'(busy_a), 64'd0);

    // Pointer now at 1: simultaneous requests go to requester 1 first.
    req_valid[0] = 1'b1;
    req_addr[0 +: AW] = 48'h4000;
    req_last[0] = 1'b1;
    access(1, 48'h5000, 1'b1, 48'hB1B1_0000_0001, "rr_ptr1");
    access(0, 48'h4000, 1'b1, 48'hB0B0_0000_0001, "rr_then0");

    // Reset while an access is outstanding.
    req_valid[0] = 1'b1;
    req_addr[0 +: AW] = 48'h6000;
    req_last[0] = 1'b1;
    cyc();
    #1;
    chk("rst_mid_busy_before", 64'(busy_a), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_gnt",      64'(gnt_a),       64'd0);
    chk("rst_mid_mem_read", 64'(mem_read_a),  64'd0);
    chk("rst_mid_busy",     64'(busy_a),      64'd0);
    chk("rst_mid_rsp",      64'(rsp_valid_a | rsp_err_a), 64'd0);
    req_valid = '0;
    req_last  = '0;
    cyc();
    cyc();
    reset_n = 1'b1;

    // Contention from reset: requester 0 keeps the port for its whole walk.
    req_valid[1] = 1'b1;
    req_addr[AW +: AW] = 48'h7000;
    req_last[1] = 1'b1;
    access(0, 48'h1000, 1'b0, 48'hC0C0_0000_0001, "cont_l1");
    // Requester 0 sits in HOLD; requester 1 must stay locked out.
    for (int i = 0; i < 10; i++) begin
      chk("hold_gnt",      64'(gnt_a),       64'b01);
      chk("hold_mem_read", 64'(mem_read_a),  64'd0);
      chk("hold_no_rsp",   64'(rsp_valid_a | rsp_err_a), 64'd0);
      cyc();
      #1;
    end
    access(0, 48'h2008, 1'b0, 48'hC0C0_0000_0002, "cont_l2");
    access(0, 48'h3010, 1'b1, 48'hC0C0_0000_0003, "cont_l3");
    access(1, 48'h7000, 1'b1, 48'hC1C1_0000_0001, "cont_r1");
    // Third contention: pointer back at 0.
    req_valid[1] = 1'b1;
    req_addr[AW +: AW] = 48'h8000;
    req_last[1] = 1'b1;
    access(0, 48'h9000, 1'b1, 48'hC0C0_0000_0004, "cont3_r0");
    access(1, 48'h8000, 1'b1, 48'hC1C1_0000_0002, "cont3_r1");

    // Timeout checks on dut_b (TIMEOUT = 8).
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    req_valid[0] = 1'b1;
    req_addr[0 +: AW] = 48'hA000;
    req_last[0] = 1'b1;
    cyc();
    #1;
    chk("tmo_gnt",      64'(gnt_b),      64'b01);
    chk("tmo_mem_addr", 64'(mem_addr_b), 64'hA000);
    chk("tmo_mem_read", 64'(mem_read_b), 64'd1);
    repeat (6) cyc();
    #1;
    chk("tmo_cycle7_no_err", 64'(rsp_err_b), 64'd0);
    cyc();
    #1;
    chk("tmo_cycle8_err",    64'(rsp_err_b),   64'b01);
    chk("tmo_cycle8_no_vld", 64'(rsp_valid_b), 64'd0);
    chk("tmo_cycle8_tcnt",   64'(tcnt_b),      64'd0);
    cyc();
    #1;
    chk("tmo_tcnt",      64'(tcnt_b),     64'd1);
    chk("tmo_released",  64'(gnt_b),      64'd0);
    chk("tmo_busy",      64'(busy_b),     64'd0);
    chk("tmo_read_drop", 64'(mem_read_b), 64'd0);
    // Both request: arbitration resumes past the timed-out owner.
    req_valid = 2'b11;
    req_addr[AW +: AW] = 48'hB000;
    req_last[1] = 1'b1;
    cyc();
    #1;
    chk("tmo_next_owner", 64'(gnt_b), 64'b10);
    // mem_ready lands exactly on the expiry cycle: data wins, no error.
    repeat (7) cyc();
    mem_ready = 1'b1;
    mem_data  = 48'h5A5A_1234_5678;
    #1;
    chk("coinc_rsp_valid", 64'(rsp_valid_b), 64'b10);
    chk("coinc_rsp_err",   64'(rsp_err_b),   64'd0);
    chk("coinc_rsp_data",  64'(rsp_data_b),  64'h5A5A_1234_5678);
    cyc();
    mem_ready    = 1'b0;
    req_valid[1] = 1'b0;
    #1;
    chk("coinc_tcnt", 64'(tcnt_b), 64'd1);
    chk("coinc_gnt",  64'(gnt_b),  64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
